// File: rtl/side_buf_pkg.sv
// side_buf_pkg: shared types and defaults for the MinBD side-buffer controller.
package side_buf_pkg;
    localparam int WIDTH_FLIT_INT = 16;
    localparam int SB_DEPTH_DEF   = 4;
    localparam int SB_STARVE_DEF  = 8;
    typedef logic [WIDTH_FLIT_INT-1:0] flit_int_t;
    typedef enum logic [1:0] {SB_IDLE, SB_WAIT, SB_REDIR} sb_state_e;
    function automatic flit_int_t clr_defl(input flit_int_t f);
        return {1'b0, f[WIDTH_FLIT_INT-2:0]};
    endfunction
endpackage

// File: rtl/side_buf_fifo.sv
// side_buf_fifo: DEPTH-entry fall-through flit store with registered full/empty.
module side_buf_fifo
    import side_buf_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  flit_int_t              wr_data,
    input  logic                   rd_en,
    output flit_int_t              rd_data,
    output logic [$clog2(DEPTH):0] count_nxt,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    flit_int_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          wr_ok, rd_ok;
    always_comb begin
        wr_ok     = wr_en & (~full | rd_en);
        rd_ok     = rd_en & ~empty;
        count_nxt = count + CW'(wr_ok) - CW'(rd_ok);
    end
    assign rd_data = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_ok);
            rd_ptr <= rd_ptr + AW'(rd_ok);
            count  <= count_nxt;
            full   <= count_nxt == CW'(DEPTH);
            empty  <= count_nxt == '0;
        end
    always_ff @(posedge clk)
        if (wr_ok) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/side_buf_ctrl.sv
// side_buf_ctrl: MinBD side-buffer controller; reinjects the head flit and forces a redirect on starvation.
// Define SIDE_BUF_STATS_EN to add redirect/deflect counters and peak-occupancy outputs.
module side_buf_ctrl
    import side_buf_pkg::*;
#(
    parameter int DEPTH         = SB_DEPTH_DEF,
    parameter int STARVE_THRESH = SB_STARVE_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   defl_vld,
    input  flit_int_t              defl_flit,
    input  logic                   redir_vld,
    input  flit_int_t              redir_flit,
    input  logic                   slot_avail,
    output logic                   reinj_vld,
    output flit_int_t              reinj_flit,
    output logic                   full,
    output logic                   empty,
    output logic                   redirect_gnt
`ifdef SIDE_BUF_STATS_EN
    ,
    output logic [31:0]            stat_redir_cnt,
    output logic [31:0]            stat_defl_cnt,
    output logic [$clog2(DEPTH):0] stat_max_occ
`endif
);
    localparam int CW = $clog2(STARVE_THRESH) + 1;
    localparam logic [CW-1:0] T_MAX = CW'(STARVE_THRESH);
    localparam logic [CW-1:0] T_GO  = CW'(STARVE_THRESH - 1);
    sb_state_e              state;
    logic [CW-1:0]          starve_cnt;
    logic [$clog2(DEPTH):0] occ_nxt;
    logic                   redir_acc, defl_acc, push, redir_go;
    flit_int_t              head;
    always_comb begin
        redir_acc  = redir_vld & redirect_gnt;
        defl_acc   = defl_vld & ~redir_vld & ~redirect_gnt & ~full;
        push       = redir_acc | defl_acc;
        reinj_vld  = ~empty & (slot_avail | redir_vld);
        reinj_flit = reinj_vld ? head : '0;
        redir_go   = (state == SB_WAIT) & ~reinj_vld & (starve_cnt >= T_GO);
    end
    side_buf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (push),
        .wr_data   (clr_defl(redir_vld ? redir_flit : defl_flit)),
        .rd_en     (reinj_vld),
        .rd_data   (head),
        .count_nxt (occ_nxt),
        .full      (full),
        .empty     (empty)
    );
    // A stalled REDIR leaves starve_cnt saturated, so WAIT re-enters REDIR on the next cycle.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state        <= SB_IDLE;
            redirect_gnt <= 1'b0;
            starve_cnt   <= '0;
        end else begin
            state        <= occ_nxt == '0 ? SB_IDLE : redir_go ? SB_REDIR : SB_WAIT;
            redirect_gnt <= redir_go;
            starve_cnt   <= (reinj_vld | empty) ? '0 : starve_cnt == T_MAX ? starve_cnt : starve_cnt + 1'b1;
        end
`ifdef SIDE_BUF_STATS_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            stat_redir_cnt <= '0;
            stat_defl_cnt  <= '0;
            stat_max_occ   <= '0;
        end else begin
            stat_redir_cnt <= stat_redir_cnt + 32'(redir_acc);
            stat_defl_cnt  <= stat_defl_cnt + 32'(defl_acc);
            if (occ_nxt > stat_max_occ) stat_max_occ <= occ_nxt;
        end
`endif
`ifndef SYNTHESIS
    a_redir_granted: assert property (@(posedge clk) disable iff (!rst_n) redir_vld |-> redirect_gnt);
    a_no_overflow:   assert property (@(posedge clk) disable iff (!rst_n) !(push & full & ~reinj_vld));
`endif
endmodule

// File: tb/tb_side_buf_ctrl.sv
// tb_side_buf_ctrl: directed checks of ordering, reset, starvation redirect and full handling.
module tb_side_buf_ctrl;
    import side_buf_pkg::*;
    logic      clk = 1'b0, rst_n = 1'b1;
    logic      defl_vld = 1'b0, redir_vld = 1'b0, slot_avail = 1'b0;
    flit_int_t defl_flit = '0, redir_flit = '0, reinj_flit;
    logic      reinj_vld, full, empty, redirect_gnt;
`ifdef SIDE_BUF_STATS_EN
    logic [31:0] stat_redir_cnt, stat_defl_cnt;
    logic [2:0]  stat_max_occ;
`endif
    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    side_buf_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .defl_vld     (defl_vld),
        .defl_flit    (defl_flit),
        .redir_vld    (redir_vld),
        .redir_flit   (redir_flit),
        .slot_avail   (slot_avail),
        .reinj_vld    (reinj_vld),
        .reinj_flit   (reinj_flit),
        .full         (full),
        .empty        (empty),
        .redirect_gnt (redirect_gnt)
`ifdef SIDE_BUF_STATS_EN
        ,
        .stat_redir_cnt (stat_redir_cnt),
        .stat_defl_cnt  (stat_defl_cnt),
        .stat_max_occ   (stat_max_occ)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input flit_int_t f);
        defl_vld  = 1'b1;
        defl_flit = f;
        tick();
        defl_vld  = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input flit_int_t f);
        slot_avail = 1'b1;
        #1;
        chk({tag, "_vld"}, 32'(reinj_vld), 32'd1);
        chk(tag, 32'(reinj_flit), 32'(f));
        tick();
        slot_avail = 1'b0;
    endtask

    task automatic wait_gnt(input int max);
        for (int i = 0; i < max && !redirect_gnt; i++) tick();
        chk("gnt_wait", 32'(redirect_gnt), 32'd1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_gnt", 32'(redirect_gnt), 32'd0);
        chk("rst_vld", 32'(reinj_vld), 32'd0);
        chk("rst_flit", 32'(reinj_flit), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        // asynchronous reset with three entries held
        push(16'h0101); push(16'h0102); push(16'h0103);
        slot_avail = 1'b1;
        #1;
        chk("pre_rst_vld", 32'(reinj_vld), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_full", 32'(full), 32'd0);
        chk("mid_rst_gnt", 32'(redirect_gnt), 32'd0);
        chk("mid_rst_vld", 32'(reinj_vld), 32'd0);
        slot_avail = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        push(16'h8777);
        pop_chk("post_rst_a", 16'h0777);
        chk("post_rst_empty", 32'(empty), 32'd1);
        // ordering, and no bypass through an empty buffer
        defl_vld   = 1'b1;
        defl_flit  = 16'h8001;
        slot_avail = 1'b1;
        #1;
        chk("no_bypass", 32'(reinj_vld), 32'd0);
        tick();
        defl_vld   = 1'b0;
        slot_avail = 1'b0;
        push(16'h0002); push(16'hC003);
        chk("ord_not_empty", 32'(empty), 32'd0);
        chk("ord_hold", 32'(reinj_vld), 32'd0);
        pop_chk("ord_a", 16'h0001);
        pop_chk("ord_b", 16'h0002);
        pop_chk("ord_c", 16'h4003);
        chk("ord_empty", 32'(empty), 32'd1);
        // starvation redirect eight cycles after the push
        push(16'h0011);
        for (int i = 0; i < 8; i++) begin
            chk("starve_wait", 32'(redirect_gnt), 32'd0);
            tick();
        end
        chk("starve_gnt", 32'(redirect_gnt), 32'd1);
        redir_vld  = 1'b1;
        redir_flit = 16'h8022;
        #1;
        chk("redir_vld", 32'(reinj_vld), 32'd1);
        chk("redir_head", 32'(reinj_flit), 32'h0011);
        tick();
        redir_vld = 1'b0;
        chk("redir_gnt_off", 32'(redirect_gnt), 32'd0);
        chk("redir_not_empty", 32'(empty), 32'd0);
        pop_chk("redir_r", 16'h0022);
        chk("redir_empty", 32'(empty), 32'd1);
        // REDIR without a redirected flit re-asserts
        push(16'h0033);
        for (int i = 0; i < 8; i++) tick();
        chk("nr_gnt", 32'(redirect_gnt), 32'd1);
        tick();
        chk("nr_gap", 32'(redirect_gnt), 32'd0);
        tick();
        chk("nr_regnt", 32'(redirect_gnt), 32'd1);
        redir_vld  = 1'b1;
        redir_flit = 16'h0044;
        #1;
        chk("nr_head", 32'(reinj_flit), 32'h0033);
        tick();
        redir_vld = 1'b0;
        pop_chk("nr_r", 16'h0044);
        chk("nr_empty", 32'(empty), 32'd1);
        // full: deflect ignored, redirect keeps occupancy
        for (int i = 0; i < 4; i++) push(flit_int_t'(16'h0100 + i));
        chk("full_set", 32'(full), 32'd1);
        defl_vld  = 1'b1;
        defl_flit = 16'h0999;
        tick();
        defl_vld = 1'b0;
        chk("full_ign", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("full_wait", 32'(redirect_gnt), 32'd0);
            tick();
        end
        chk("full_gnt", 32'(redirect_gnt), 32'd1);
        redir_vld  = 1'b1;
        redir_flit = 16'h0555;
        #1;
        chk("full_head", 32'(reinj_flit), 32'h0100);
        tick();
        redir_vld = 1'b0;
        chk("full_hold", 32'(full), 32'd1);
        chk("full_gnt_off", 32'(redirect_gnt), 32'd0);
        pop_chk("full_p1", 16'h0101);
        chk("full_clr", 32'(full), 32'd0);
        pop_chk("full_p2", 16'h0102);
        pop_chk("full_p3", 16'h0103);
        pop_chk("full_p4", 16'h0555);
        chk("full_empty", 32'(empty), 32'd1);
`ifdef SIDE_BUF_STATS_EN
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("stat_rst_occ", 32'(stat_max_occ), 32'd0);
        push(16'h0001); push(16'h0002);
        slot_avail = 1'b1;
        push(16'h0003); push(16'h0004); push(16'h0005);
        slot_avail = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wait_gnt(12);
            redir_vld  = 1'b1;
            redir_flit = 16'h0006;
            tick();
            redir_vld = 1'b0;
        end
        chk("stat_defl", stat_defl_cnt, 32'd5);
        chk("stat_redir", stat_redir_cnt, 32'd2);
        chk("stat_max_occ", 32'(stat_max_occ), 32'd2);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
